// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one single-port memory between instruction fetch
// and load/store. It serialises accesses and returns read data to the owner.
module mem_arbiter #(
  parameter int ADDR_WIDTH  = 8,
  parameter int DATA_WIDTH  = 16,
  parameter int MEM_LATENCY = 1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  fetch_req,
  input  logic [ADDR_WIDTH-1:0] fetch_addr,
  output logic                  fetch_ack,
  output logic [DATA_WIDTH-1:0] fetch_rdata,
  input  logic                  data_req,
  input  logic                  data_we,
  input  logic [ADDR_WIDTH-1:0] data_addr,
  input  logic [DATA_WIDTH-1:0] data_wdata,
  output logic                  data_ack,
  output logic [DATA_WIDTH-1:0] data_rdata,
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  busy
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_e;

  state_e                state_q, state_d;
  logic                  owner_q, owner_d;           // 1 = load/store path
  logic                  last_grant_q, last_grant_d; // 1 = load/store path
  logic                  we_q, we_d;
  logic [2:0]            cnt_q, cnt_d;
  logic                  mem_en_q, mem_en_d;
  logic                  mem_we_q, mem_we_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
  logic                  fetch_ack_q, fetch_ack_d;
  logic                  data_ack_q, data_ack_d;
  logic [DATA_WIDTH-1:0] fetch_rdata_q, fetch_rdata_d;
  logic [DATA_WIDTH-1:0] data_rdata_q, data_rdata_d;
  logic                  busy_q, busy_d;
  logic                  grant_data;

  always_comb begin
    state_d       = state_q;
    owner_d       = owner_q;
    last_grant_d  = last_grant_q;
    we_d          = we_q;
    cnt_d         = cnt_q;
    mem_en_d      = 1'b0;
    mem_we_d      = 1'b0;
    mem_addr_d    = mem_addr_q;
    mem_wdata_d   = mem_wdata_q;
    fetch_ack_d   = 1'b0;
    data_ack_d    = 1'b0;
    fetch_rdata_d = fetch_rdata_q;
    data_rdata_d  = data_rdata_q;
    busy_d        = busy_q;
    grant_data    = 1'b0;
    case (state_q)
      IDLE: begin
        if (fetch_req || data_req) begin
          // Under contention the side that did not win last time gets the port.
          grant_data   = data_req && (!fetch_req || !last_grant_q);
          owner_d      = grant_data;
          last_grant_d = grant_data;
          we_d         = grant_data && data_we;
          mem_addr_d   = grant_data ? data_addr : fetch_addr;
          if (grant_data) mem_wdata_d = data_wdata;
          mem_en_d     = 1'b1;
          mem_we_d     = grant_data && data_we;
          busy_d       = 1'b1;
          state_d      = ISSUE;
        end
      end
      ISSUE: begin
        if (we_q) begin
          data_ack_d = owner_q;
          state_d    = RESP;
        end else begin
          cnt_d   = 3'(MEM_LATENCY);
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (cnt_q == 3'd1) begin
          if (owner_q) data_rdata_d = mem_rdata;
          else         fetch_rdata_d = mem_rdata;
          fetch_ack_d = !owner_q;
          data_ack_d  = owner_q;
          state_d     = RESP;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      RESP: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= IDLE;
      owner_q       <= 1'b0;
      last_grant_q  <= 1'b1;
      we_q          <= 1'b0;
      cnt_q         <= '0;
      mem_en_q      <= 1'b0;
      mem_we_q      <= 1'b0;
      mem_addr_q    <= '0;
      mem_wdata_q   <= '0;
      fetch_ack_q   <= 1'b0;
      data_ack_q    <= 1'b0;
      fetch_rdata_q <= '0;
      data_rdata_q  <= '0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      owner_q       <= owner_d;
      last_grant_q  <= last_grant_d;
      we_q          <= we_d;
      cnt_q         <= cnt_d;
      mem_en_q      <= mem_en_d;
      mem_we_q      <= mem_we_d;
      mem_addr_q    <= mem_addr_d;
      mem_wdata_q   <= mem_wdata_d;
      fetch_ack_q   <= fetch_ack_d;
      data_ack_q    <= data_ack_d;
      fetch_rdata_q <= fetch_rdata_d;
      data_rdata_q  <= data_rdata_d;
      busy_q        <= busy_d;
    end
  end

  assign fetch_ack   = fetch_ack_q;
  assign fetch_rdata = fetch_rdata_q;
  assign data_ack    = data_ack_q;
  assign data_rdata  = data_rdata_q;
  assign mem_en      = mem_en_q;
  assign mem_we      = mem_we_q;
  assign mem_addr    = mem_addr_q;
  assign mem_wdata   = mem_wdata_q;
  assign busy        = busy_q;

endmodule
